// File: rtl/asteroid_wave_ctrl.sv
// Level/wave scheduler for the asteroid field: launches levels on the quads,
// detects a fully cleared level, waits an inter-level gap in frames, then
// launches the next level. All outputs are registered.
module asteroid_wave_ctrl #(
  parameter int unsigned NQUADS     = 4,
  parameter int unsigned GAP_FRAMES = 120,
  parameter int unsigned MAX_LEVEL  = 15,
  parameter int unsigned LEVEL_W    = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               vsync,
  input  logic               start_done,
  input  logic               game_over,
  input  logic [NQUADS-1:0]  quad_clear,
  output logic [NQUADS-1:0]  new_level,
  output logic [NQUADS-1:0]  quad_en,
  output logic [LEVEL_W-1:0] level,
  output logic               level_up,
  output logic [2:0]         wave_state
);

  localparam int unsigned CW = $clog2(GAP_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    PLAY       = 3'd2,
    CLEAR_WAIT = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [LEVEL_W-1:0]  level_nx, level_inc;
  logic [CW-1:0]       gap, gap_nx;
  logic [NQUADS-1:0]   mask_cur, mask_nx, new_level_nx, quad_en_nx;
  logic                level_up_nx, all_clear;

  // Low min(lv, NQUADS) bits set; compare done in LEVEL_W-bit unsigned arithmetic
  function automatic logic [NQUADS-1:0] mask_of(input logic [LEVEL_W-1:0] lv);
    logic [NQUADS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NQUADS; i++) begin
      m[i] = (lv > LEVEL_W'(i));
    end
    return m;
  endfunction

  assign mask_cur   = mask_of(level);
  assign all_clear  = &(quad_clear | ~mask_cur);
  assign level_inc  = (level >= LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                     : level + LEVEL_W'(1);
  assign wave_state = state;

  // Next-state, level/gap update and next registered outputs
  always_comb begin
    state_nx = state;
    level_nx = level;
    gap_nx   = gap;
    if (state == IDLE) begin
      if (start_done && !game_over) begin
        state_nx = LAUNCH;
        level_nx = LEVEL_W'(1);
      end
    end else if (!start_done) begin
      state_nx = IDLE;
      level_nx = '0;
      gap_nx   = '0;
    end else if (game_over && state != GAME_OVER) begin
      state_nx = GAME_OVER;
    end else begin
      case (state)
        LAUNCH: if (vsync) state_nx = PLAY;
        PLAY: begin
          if (vsync && all_clear) begin
            state_nx = CLEAR_WAIT;
            gap_nx   = CW'(GAP_FRAMES);
          end
        end
        CLEAR_WAIT: begin
          if (vsync) begin
            if (gap == CW'(1)) begin
              state_nx = LAUNCH;
              level_nx = level_inc;
              gap_nx   = '0;
            end else begin
              gap_nx = gap - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // Outputs are derived from the next state so the flops line up with it
    mask_nx      = mask_of(level_nx);
    new_level_nx = (state_nx == LAUNCH) ? mask_nx : '0;
    quad_en_nx   = (state_nx == LAUNCH || state_nx == PLAY || state_nx == CLEAR_WAIT)
                   ? mask_nx : '0;
    level_up_nx  = (state == LAUNCH) && (state_nx == PLAY);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      level     <= '0;
      gap       <= '0;
      new_level <= '0;
      quad_en   <= '0;
      level_up  <= 1'b0;
    end else begin
      state     <= state_nx;
      level     <= level_nx;
      gap       <= gap_nx;
      new_level <= new_level_nx;
      quad_en   <= quad_en_nx;
      level_up  <= level_up_nx;
    end
  end

endmodule

// File: tb/tb_asteroid_wave_ctrl.sv
// Directed bench for asteroid_wave_ctrl (NQUADS=4, GAP_FRAMES=3, MAX_LEVEL=6).
module tb_asteroid_wave_ctrl;

  logic       clk = 1'b0;
  logic       resetN, vsync, start_done, game_over;
  logic [3:0] quad_clear, new_level, quad_en, level;
  logic       level_up;
  logic [2:0] wave_state;

  int total = 0;
  int bad   = 0;

  asteroid_wave_ctrl #(
    .NQUADS(4), .GAP_FRAMES(3), .MAX_LEVEL(6), .LEVEL_W(4)
  ) dut (
    .clk(clk), .resetN(resetN), .vsync(vsync), .start_done(start_done),
    .game_over(game_over), .quad_clear(quad_clear), .new_level(new_level),
    .quad_en(quad_en), .level(level), .level_up(level_up), .wave_state(wave_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  // One full clear cycle from PLAY back into PLAY at the next level
  task automatic advance(input logic [7:0] lvl, input logic [7:0] msk);
    vs();
    chk("adv_cw", 8'(wave_state), 8'h3);
    vs();
    vs();
    vs();
    chk("adv_launch", 8'(wave_state), 8'h1);
    chk("adv_new_level", 8'(new_level), msk);
    vs();
    chk("adv_play", 8'(wave_state), 8'h2);
    chk("adv_level", 8'(level), lvl);
    chk("adv_level_up", 8'(level_up), 8'h1);
    chk("adv_quad_en", 8'(quad_en), msk);
  endtask

  initial begin
    resetN = 1'b0; vsync = 1'b0; start_done = 1'b0; game_over = 1'b0; quad_clear = '0;
    tick(); tick();
    chk("rst_state", 8'(wave_state), 8'h0);
    chk("rst_level", 8'(level), 8'h0);
    chk("rst_new_level", 8'(new_level), 8'h0);
    chk("rst_quad_en", 8'(quad_en), 8'h0);
    chk("rst_level_up", 8'(level_up), 8'h0);

    // 1: start with a vsync on the IDLE->LAUNCH edge; it must not be consumed
    resetN = 1'b1; start_done = 1'b1;
    vs();
    chk("s1_launch", 8'(wave_state), 8'h1);
    chk("s1_level", 8'(level), 8'h1);
    chk("s1_new_level", 8'(new_level), 8'h1);
    chk("s1_quad_en", 8'(quad_en), 8'h1);
    tick(); tick();
    chk("s1_still_launch", 8'(wave_state), 8'h1);
    vsync = 1'b1;
    chk("s1_nl_on_vsync", 8'(new_level), 8'h1);
    tick(); vsync = 1'b0;
    chk("s1_play", 8'(wave_state), 8'h2);
    chk("s1_nl_low", 8'(new_level), 8'h0);
    chk("s1_level_up", 8'(level_up), 8'h1);
    chk("s1_quad_en_play", 8'(quad_en), 8'h1);
    tick();
    chk("s1_level_up_once", 8'(level_up), 8'h0);

    // 2: clear seen off-vsync is ignored; on vsync it enters the gap
    quad_clear = 4'b0001;
    tick(); tick();
    chk("s2_no_vsync", 8'(wave_state), 8'h2);
    vs();
    chk("s2_cw", 8'(wave_state), 8'h3);
    chk("s2_cw_quad_en", 8'(quad_en), 8'h1);
    vs(); vs();
    chk("s2_gap_2", 8'(wave_state), 8'h3);
    vs();
    chk("s2_launch", 8'(wave_state), 8'h1);
    chk("s2_level", 8'(level), 8'h2);
    chk("s2_new_level", 8'(new_level), 8'h3);
    vs();
    chk("s2_play", 8'(wave_state), 8'h2);
    // quad 1 still alive at level 2
    vs();
    chk("s2_partial", 8'(wave_state), 8'h2);

    // 3: consecutive clears, mask saturates at 4 quads, level saturates at 6
    quad_clear = 4'b1111;
    advance(8'h3, 8'h7);
    advance(8'h4, 8'hF);
    advance(8'h5, 8'hF);
    advance(8'h6, 8'hF);
    advance(8'h6, 8'hF);

    // 4: game_over wins over the expiring vsync in CLEAR_WAIT
    vs(); vs(); vs();
    chk("s4_cw", 8'(wave_state), 8'h3);
    game_over = 1'b1;
    vs();
    chk("s4_go", 8'(wave_state), 8'h4);
    chk("s4_go_quad_en", 8'(quad_en), 8'h0);
    chk("s4_go_nl", 8'(new_level), 8'h0);
    chk("s4_go_level", 8'(level), 8'h6);
    chk("s4_go_level_up", 8'(level_up), 8'h0);
    game_over = 1'b0;
    tick();
    chk("s4_go_hold", 8'(wave_state), 8'h4);
    start_done = 1'b0;
    tick();
    chk("s4_idle", 8'(wave_state), 8'h0);
    chk("s4_idle_level", 8'(level), 8'h0);

    // 5: abort mid-LAUNCH
    start_done = 1'b1;
    tick(); tick();
    chk("s5_launch", 8'(wave_state), 8'h1);
    start_done = 1'b0;
    tick();
    chk("s5_idle", 8'(wave_state), 8'h0);
    chk("s5_nl", 8'(new_level), 8'h0);
    chk("s5_quad_en", 8'(quad_en), 8'h0);
    chk("s5_level_up", 8'(level_up), 8'h0);
    tick();
    chk("s5_level_up_later", 8'(level_up), 8'h0);

    // 6: reset in PLAY at level 3, then restart
    start_done = 1'b1;
    tick(); vs();
    chk("s6_play1", 8'(wave_state), 8'h2);
    quad_clear = 4'b1111;
    advance(8'h2, 8'h3);
    advance(8'h3, 8'h7);
    resetN = 1'b0;
    tick();
    chk("s6_rst_state", 8'(wave_state), 8'h0);
    chk("s6_rst_level", 8'(level), 8'h0);
    chk("s6_rst_quad_en", 8'(quad_en), 8'h0);
    chk("s6_rst_nl", 8'(new_level), 8'h0);
    chk("s6_rst_level_up", 8'(level_up), 8'h0);
    resetN = 1'b1; quad_clear = '0;
    tick();
    chk("s6_relaunch", 8'(wave_state), 8'h1);
    chk("s6_relaunch_nl", 8'(new_level), 8'h1);
    vs();
    chk("s6_replay", 8'(wave_state), 8'h2);
    chk("s6_level_up", 8'(level_up), 8'h1);
    chk("s6_quad_en", 8'(quad_en), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
